// File: rtl/hrmf_pkg.sv
// Shared types and constants for the HRMF stage sequencing controller.
package hrmf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } hrmf_state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam int CPLX_W = 64;

endpackage

// File: rtl/hrmf_lat_pipe.sv
// MTU_LAT-deep {valid, last} shift register mirroring the transpose-unit latency,
// with a synchronous clear that drops every in-flight flag.
module hrmf_lat_pipe #(
  parameter int MTU_LAT = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic shift_vld,
  input  logic shift_last,
  output logic tail_vld,
  output logic tail_last,
  output logic empty
);

  logic [MTU_LAT-1:0] vld_p;
  logic [MTU_LAT-1:0] last_p;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= shift_vld;
      last_p[0] <= shift_last;
      for (int i = 1; i < MTU_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  assign tail_vld  = vld_p[MTU_LAT-1];
  assign tail_last = last_p[MTU_LAT-1];
  assign empty     = ~|vld_p;

endmodule

// File: rtl/hrmf_ctrl.sv
// HRMF stage sequencing controller: phase select, latency tracking, twiddle addressing.
// Optional HRMF_CTRL_LASTCHK_EN: abort the frame when IN_LAST disagrees with the beat count.
module hrmf_ctrl
  import hrmf_pkg::*;
#(
  parameter int N_LOG2  = 8,
  parameter int MTU_LAT = 3,
  parameter int TF_AW   = N_LOG2 - 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [1:0]       SEL_HRMF,
  output logic             TF_EN,
  output logic [TF_AW-1:0] TF_ADDR,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  output logic             BUSY,
  output logic             ERR,
  output logic [15:0]      FRAME_CNT
);

  localparam int            CW     = N_LOG2 - 2;
  localparam logic [CW-1:0] IN_MAX = '1;

  hrmf_state_t   state, state_nxt;
  logic [CW-1:0] in_cnt, in_cnt_nxt, out_cnt;
  logic [1:0]    sel_q, sel_nxt;
  logic          busy_q, err_q;
  logic [15:0]   frame_cnt;
  logic          out_vld, out_last, pipe_empty;
  logic          accept, term, underrun, last_err, abort;

  // Mid-frame the datapath cannot stall, so RUN always accepts.
  assign IN_READY = !RST && ((state == RUN) || ENABLE);
  assign accept   = IN_VALID && IN_READY;
  assign term     = (state == RUN) && (in_cnt == IN_MAX);
  assign underrun = (state == RUN) && !IN_VALID;

`ifdef HRMF_CTRL_LASTCHK_EN
  assign last_err = accept && (IN_LAST != term);
`else
  logic unused_last;
  assign unused_last = IN_LAST;
  assign last_err    = 1'b0;
`endif

  assign abort = underrun || last_err;

  always_comb begin
    state_nxt  = state;
    in_cnt_nxt = in_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = RUN;
          in_cnt_nxt = CW'(1);
        end
      end
      RUN: begin
        if (accept) begin
          in_cnt_nxt = in_cnt + CW'(1);
          if (term) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          state_nxt  = RUN;
          in_cnt_nxt = CW'(1);
        end else if (pipe_empty) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt  = IDLE;
      in_cnt_nxt = '0;
    end
  end

  // The transpose unit keeps shifting while draining, so the phase free-runs there.
  always_comb begin
    sel_nxt = PH0;
    case (state_nxt)
      RUN:     sel_nxt = in_cnt_nxt[1:0];
      DRAIN:   sel_nxt = sel_q + 2'd1;
      default: sel_nxt = PH0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      in_cnt    <= '0;
      sel_q     <= PH0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      out_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state  <= state_nxt;
      in_cnt <= in_cnt_nxt;
      sel_q  <= sel_nxt;
      busy_q <= (state_nxt != IDLE);
      err_q  <= abort;
      if (abort)         out_cnt <= '0;
      else if (out_vld)  out_cnt <= out_last ? '0 : out_cnt + CW'(1);
      if (out_vld && out_last && !abort) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  hrmf_lat_pipe #(
    .MTU_LAT(MTU_LAT)
  ) u_lat_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (abort),
    .shift_vld (accept),
    .shift_last(accept && term),
    .tail_vld  (out_vld),
    .tail_last (out_last),
    .empty     (pipe_empty)
  );

  assign SEL_HRMF  = sel_q;
  assign TF_EN     = out_vld;
  assign TF_ADDR   = TF_AW'(out_cnt);
  assign OUT_VALID = out_vld;
  assign OUT_LAST  = out_last;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign FRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_hrmf_ctrl.sv
// Directed bench for hrmf_ctrl with N_LOG2=4 (4-beat frames) and MTU_LAT=3.
module tb_hrmf_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ENABLE, IN_VALID, IN_LAST;
  logic        IN_READY, TF_EN, OUT_VALID, OUT_LAST, BUSY, ERR;
  logic [1:0]  SEL_HRMF, TF_ADDR;
  logic [15:0] FRAME_CNT;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;

  hrmf_ctrl #(.N_LOG2(4), .MTU_LAT(3), .TF_AW(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ENABLE   (ENABLE),
    .IN_VALID (IN_VALID),
    .IN_LAST  (IN_LAST),
    .IN_READY (IN_READY),
    .SEL_HRMF (SEL_HRMF),
    .TF_EN    (TF_EN),
    .TF_ADDR  (TF_ADDR),
    .OUT_VALID(OUT_VALID),
    .OUT_LAST (OUT_LAST),
    .BUSY     (BUSY),
    .ERR      (ERR),
    .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        en, vld, last, rdy;
    logic [1:0]  sel;
    logic        ov, ol;
    logic [1:0]  addr;
    logic        busy, err;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(input logic en, vld, last, rdy, input logic [1:0] sel,
                              input logic ov, ol, input logic [1:0] addr,
                              input logic busy, err, input logic [15:0] fc);
    vec_t v;
    v.en = en; v.vld = vld; v.last = last; v.rdy = rdy; v.sel = sel;
    v.ov = ov; v.ol = ol; v.addr = addr; v.busy = busy; v.err = err; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, v, l);
    RST = r; ENABLE = e; IN_VALID = v; IN_LAST = l;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input int t, input logic rdy, input logic [1:0] sel,
                         input logic ov, ol, input logic [1:0] addr,
                         input logic busy, err, input int fc);
    chk($sformatf("%s[%0d].in_ready", tag, t), {31'd0, IN_READY}, {31'd0, rdy});
    chk($sformatf("%s[%0d].sel", tag, t), {30'd0, SEL_HRMF}, {30'd0, sel});
    chk($sformatf("%s[%0d].out_valid", tag, t), {31'd0, OUT_VALID}, {31'd0, ov});
    chk($sformatf("%s[%0d].tf_en", tag, t), {31'd0, TF_EN}, {31'd0, ov});
    chk($sformatf("%s[%0d].out_last", tag, t), {31'd0, OUT_LAST}, {31'd0, ol});
    chk($sformatf("%s[%0d].tf_addr", tag, t), {30'd0, TF_ADDR}, {30'd0, addr});
    chk($sformatf("%s[%0d].busy", tag, t), {31'd0, BUSY}, {31'd0, busy});
    chk($sformatf("%s[%0d].err", tag, t), {31'd0, ERR}, {31'd0, err});
    chk($sformatf("%s[%0d].frame_cnt", tag, t), {16'd0, FRAME_CNT}, fc);
  endtask

  // nf contiguous frames from IDLE; last output lands at offset 4*nf+2.
  task automatic run_frames(input int nf, input string tag);
    int nb, lo, k_done;
    logic ov;
    nb = 4 * nf;
    lo = nb + 2;
    for (int t = 0; t <= lo + 3; t++) begin
      drive(1'b0, 1'b1, t < nb, (t < nb) && (t % 4 == 3));
      ov = (t >= 3) && (t <= lo);
      k_done = 0;
      for (int k = 0; k < nf; k++) if (4 * k + 6 < t) k_done++;
      chk_all(tag, t, 1'b1, (t <= lo + 1) ? 2'(t % 4) : 2'd0, ov,
              ov && ((t - 3) % 4 == 3), ov ? 2'((t - 3) % 4) : 2'd0,
              (t >= 1) && (t <= lo + 1), 1'b0, exp_fc + k_done);
      tick();
    end
    exp_fc += nf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with ENABLE and IN_VALID high: nothing may be accepted.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk_all("reset", 0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0);

    // Single frame at cycle 10, then enable gating and mid-frame ENABLE drop.
    for (int i = 0; i < 10; i++) tbl[i] = mk(1,0,0,1, 2'd0, 0,0, 2'd0, 0,0, 16'd0);
    tbl[10] = mk(1,1,0,1, 2'd0, 0,0, 2'd0, 0,0, 16'd0);
    tbl[11] = mk(1,1,0,1, 2'd1, 0,0, 2'd0, 1,0, 16'd0);
    tbl[12] = mk(1,1,0,1, 2'd2, 0,0, 2'd0, 1,0, 16'd0);
    tbl[13] = mk(1,1,1,1, 2'd3, 1,0, 2'd0, 1,0, 16'd0);
    tbl[14] = mk(1,0,0,1, 2'd0, 1,0, 2'd1, 1,0, 16'd0);
    tbl[15] = mk(1,0,0,1, 2'd1, 1,0, 2'd2, 1,0, 16'd0);
    tbl[16] = mk(1,0,0,1, 2'd2, 1,1, 2'd3, 1,0, 16'd0);
    tbl[17] = mk(1,0,0,1, 2'd3, 0,0, 2'd0, 1,0, 16'd1);
    tbl[18] = mk(1,0,0,1, 2'd0, 0,0, 2'd0, 0,0, 16'd1);
    tbl[19] = mk(0,1,0,0, 2'd0, 0,0, 2'd0, 0,0, 16'd1);
    tbl[20] = mk(0,1,0,0, 2'd0, 0,0, 2'd0, 0,0, 16'd1);
    tbl[21] = mk(1,1,0,1, 2'd0, 0,0, 2'd0, 0,0, 16'd1);
    tbl[22] = mk(1,1,0,1, 2'd1, 0,0, 2'd0, 1,0, 16'd1);
    tbl[23] = mk(0,1,0,1, 2'd2, 0,0, 2'd0, 1,0, 16'd1);
    tbl[24] = mk(0,1,1,1, 2'd3, 1,0, 2'd0, 1,0, 16'd1);
    tbl[25] = mk(0,0,0,0, 2'd0, 1,0, 2'd1, 1,0, 16'd1);
    tbl[26] = mk(1,0,0,1, 2'd1, 1,0, 2'd2, 1,0, 16'd1);
    tbl[27] = mk(1,0,0,1, 2'd2, 1,1, 2'd3, 1,0, 16'd1);
    tbl[28] = mk(1,0,0,1, 2'd3, 0,0, 2'd0, 1,0, 16'd2);
    tbl[29] = mk(1,0,0,1, 2'd0, 0,0, 2'd0, 0,0, 16'd2);
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, tbl[i].en, tbl[i].vld, tbl[i].last);
      chk_all("table", i, tbl[i].rdy, tbl[i].sel, tbl[i].ov, tbl[i].ol, tbl[i].addr,
              tbl[i].busy, tbl[i].err, int'(tbl[i].fc));
      tick();
    end
    exp_fc = 2;

    run_frames(3, "b2b");

    // Underrun at beat 2: ERR pulse, pipe flushed, no frame counted.
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, 1'b1, t < 2, 1'b0);
      chk_all("underrun", t, 1'b1, (t < 3) ? 2'(t) : 2'd0, 1'b0, 1'b0, 2'd0,
              (t == 1) || (t == 2), t == 3, exp_fc);
      tick();
    end

    run_frames(1, "recover");

    // Underrun of the next frame coincides with the previous frame's final output.
    for (int t = 0; t < 9; t++) begin
      drive(1'b0, 1'b1, t < 6, t == 3);
      chk_all("uflow_last", t, 1'b1, (t < 7) ? 2'(t % 4) : 2'd0,
              (t >= 3) && (t <= 6), t == 6, ((t >= 3) && (t <= 6)) ? 2'(t - 3) : 2'd0,
              (t >= 1) && (t <= 6), t == 7, exp_fc);
      tick();
    end

    // IN_LAST raised on beat 1.
    for (int t = 0; t < 10; t++) begin
      logic [1:0] s;
      logic b, e, ov, ol;
      int fc;
      drive(1'b0, 1'b1, t < 4, t == 1);
`ifdef HRMF_CTRL_LASTCHK_EN
      case (t)
        1, 3:    s = 2'd1;
        4:       s = 2'd2;
        default: s = 2'd0;
      endcase
      b  = (t == 1) || (t == 3) || (t == 4);
      e  = (t == 2) || (t == 5);
      ov = 1'b0;
      ol = 1'b0;
      fc = exp_fc;
`else
      s  = (t < 8) ? 2'(t % 4) : 2'd0;
      b  = (t >= 1) && (t <= 7);
      e  = 1'b0;
      ov = (t >= 3) && (t <= 6);
      ol = t == 6;
      fc = exp_fc + ((t > 6) ? 1 : 0);
`endif
      chk_all("lastchk", t, 1'b1, s, ov, ol, ov ? 2'(t - 3) : 2'd0, b, e, fc);
      tick();
    end
`ifndef HRMF_CTRL_LASTCHK_EN
    exp_fc += 1;
`endif

    // Reset asserted at beat 2: all state returns to reset values, nothing emerges.
    for (int t = 0; t < 9; t++) begin
      drive(t == 2, 1'b1, t < 3, 1'b0);
      if (t <= 2)
        chk_all("rst_mid", t, t != 2, 2'(t), 1'b0, 1'b0, 2'd0, t != 0, 1'b0, exp_fc);
      else
        chk_all("rst_mid", t, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0);
      tick();
    end
    exp_fc = 0;

    run_frames(1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
